// File: rtl/mem_ctrl_if.sv
// Request/response handshake between system logic and mem_ctrl.
// master: requester (valid/we/addr/wdata out); slave: mem_ctrl.
interface mem_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/mem_ctrl.sv
// Synchronous front-end for a 32x8 async RAM: request handshake to
// timed addr/read/write strobes, owns the bidirectional data bus.
// Ports: clk, rst_n (sync, active low); s_req (mem_ctrl_if.slave);
//   mem_addr/mem_read/mem_write to RAM; mem_data inout to RAM.
// Optional: MEM_CTRL_INIT_CLEAR_EN zero-fills the RAM after reset.
module mem_ctrl #(
  parameter int AW        = 5,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int RD_WAIT   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_ctrl_if.slave     s_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  inout  wire  [DW-1:0] mem_data
);

  localparam int MX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MX    = (MX_SP > RD_WAIT) ? MX_SP : RD_WAIT;
  localparam int CW    = $clog2(MX) + 1;

  localparam logic [CW-1:0] SET_END = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PUL_END = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] RD_END  = CW'(RD_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_W_SETUP,
    ST_W_PULSE,
    ST_W_HOLD,
    ST_R_WAIT,
    ST_R_CAP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_read;
  logic          r_write;
  logic          r_oe;
  logic          r_rsp_valid;
  logic          r_ready;
`ifdef MEM_CTRL_INIT_CLEAR_EN
  logic          r_sweep;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef MEM_CTRL_INIT_CLEAR_EN
      r_state <= ST_INIT;
      r_sweep <= 1'b1;
`else
      r_state <= ST_IDLE;
`endif
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_oe        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (s_req.req_valid && r_ready) begin
            r_ready <= 1'b0;
            r_addr  <= s_req.req_addr;
            r_wdata <= s_req.req_wdata;
            r_cnt   <= '0;
            if (s_req.req_we) begin
              r_oe    <= 1'b1;
              r_state <= ST_W_SETUP;
            end else begin
              r_read  <= 1'b1;
              r_state <= ST_R_WAIT;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
`ifdef MEM_CTRL_INIT_CLEAR_EN
        // r_addr doubles as the sweep pointer
        ST_INIT: begin
          r_wdata <= '0;
          r_oe    <= 1'b1;
          r_cnt   <= '0;
          r_state <= ST_W_SETUP;
        end
`endif
        ST_W_SETUP: begin
          if (r_cnt == SET_END) begin
            r_cnt   <= '0;
            r_write <= 1'b1;
            r_state <= ST_W_PULSE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_W_PULSE: begin
          if (r_cnt == PUL_END) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_state <= ST_W_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_W_HOLD: begin
          r_oe <= 1'b0;
`ifdef MEM_CTRL_INIT_CLEAR_EN
          if (r_sweep) begin
            // last word wraps the pointer back to 0
            r_addr <= r_addr + 1'b1;
            if (&r_addr) begin
              r_sweep <= 1'b0;
              r_ready <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_INIT;
            end
          end else begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
`else
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
`endif
        end
        ST_R_WAIT: begin
          if (r_cnt == RD_END) begin
            r_read      <= 1'b0;
            r_rdata     <= mem_data;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_R_CAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_R_CAP: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr        = r_addr;
  assign mem_read        = r_read;
  assign mem_write       = r_write;
  assign mem_data        = r_oe ? r_wdata : {DW{1'bz}};
  assign s_req.req_ready = r_ready;
  assign s_req.rsp_valid = r_rsp_valid;
  assign s_req.rsp_rdata = r_rdata;
  assign s_req.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural
// 32x8 RAM on the tristate data bus and a strobe-protocol monitor.
module tb_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         n_chk = 0;
  int         n_err = 0;

  logic [4:0] mem_addr;
  logic       mem_read;
  logic       mem_write;
  wire  [7:0] mem_data;
  logic [7:0] ram [32];

`ifdef MEM_CTRL_INIT_CLEAR_EN
  localparam int   RDY_LAT = 128;
  localparam logic INIT_B  = 1'b1;
`else
  localparam int   RDY_LAT = 1;
  localparam logic INIT_B  = 1'b0;
`endif

  mem_ctrl_if #(.AW(5), .DW(8)) bus ();

  mem_ctrl #(
    .AW(5), .DW(8),
    .SETUP_CYC(1), .PULSE_CYC(1), .RD_WAIT(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_req     (bus.slave),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  assign mem_data = mem_read ? ram[mem_addr] : 8'hzz;

  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_data;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  logic       p_strb = 1'b0;
  logic       p_wr = 1'b0;
  logic [4:0] p_addr = '0;
  logic [7:0] p_data = '0;

  always @(negedge clk) begin
    if (rst_n && (mem_read || mem_write)) begin
      chk("rw_ovl", 32'(mem_read & mem_write), 32'h0);
      if (p_strb) chk("addr_stb", 32'(mem_addr), 32'(p_addr));
      if (mem_write && !p_wr)
        chk("wr_setup", 32'({mem_addr, mem_data}),
            32'({p_addr, p_data}));
    end
    p_strb <= mem_read | mem_write;
    p_wr   <= mem_write;
    p_addr <= mem_addr;
    p_data <= mem_data;
  end

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.req_ready), 32'h1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    logic [3:0] wv;
    wait_rdy("wr_rdy");
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      wv[i] = mem_write;
    end
    chk("wr_seq", 32'({bus.req_ready, wv}), 32'h12);
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] e);
    logic [3:0] rv;
    logic [7:0] d;
    d = '0;
    wait_rdy("rd_rdy");
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      rv[i] = bus.rsp_valid;
      if (i == 2) d = bus.rsp_rdata;
    end
    chk("rd_seq", 32'({bus.req_ready, rv}), 32'h14);
    chk("rd_dat", 32'(d), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int         n;
    int         acc;
    int         ac [2];
    logic [9:0] bv;
    logic [7:0] bd [2];

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out",
        32'({mem_read, mem_write, mem_addr, bus.rsp_valid,
             bus.rsp_rdata, bus.req_ready, bus.busy}),
        32'(INIT_B));
    rst_n = 1'b1;

    n = 0;
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_lat", 32'(n), 32'(RDY_LAT));

`ifdef MEM_CTRL_INIT_CLEAR_EN
    rd(5'h03, 8'h00);
    rd(5'h1F, 8'h00);
`endif

    wr(5'h0A, 8'hAA);
    rd(5'h0A, 8'hAA);

    for (int i = 0; i < 32; i++)
      wr(5'(i), i[0] ? 8'h55 : 8'hAA);
    for (int i = 5; i < 10; i++)
      rd(5'(i), i[0] ? 8'h55 : 8'hAA);
    rd(5'h00, 8'hAA);
    rd(5'h1F, 8'h55);

    // two reads with req_valid held high
    wait_rdy("b2b_rdy");
    acc = 0;
    ac[0] = -1;
    ac[1] = -1;
    bd[0] = '0;
    bd[1] = '0;
    bv = '0;
    bus.req_we    = 1'b0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (acc == 2) bus.req_valid = 1'b0;
      bus.req_addr = (acc == 0) ? 5'h05 : 5'h06;
      bv[i] = bus.rsp_valid;
      if (bus.rsp_valid && i < 4) bd[0] = bus.rsp_rdata;
      if (bus.rsp_valid && i >= 4) bd[1] = bus.rsp_rdata;
      if (bus.req_valid && bus.req_ready && acc < 2) begin
        ac[acc] = i;
        acc++;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b_acc0", 32'(ac[0]), 32'd0);
    chk("b2b_acc1", 32'(ac[1]), 32'd4);
    chk("b2b_rsp", 32'(bv), 32'h088);
    chk("b2b_d0", 32'(bd[0]), 32'h55);
    chk("b2b_d1", 32'(bd[1]), 32'hAA);

    // reset while write strobe is high
    wait_rdy("rp_rdy");
    bus.req_we    = 1'b1;
    bus.req_addr  = 5'h10;
    bus.req_wdata = 8'h77;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rp_pulse", 32'(mem_write), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rp_abort",
        32'({mem_write, mem_read, bus.rsp_valid,
             bus.busy, bus.req_ready}),
        32'({INIT_B, 1'b0}));
    rst_n = 1'b1;

    wr(5'h1F, 8'h3C);
    rd(5'h1F, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
